bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-port (data / instruction) arbiter onto a single shared downstream bus.
// One transaction outstanding at a time; data port wins ties unless the
// instruction port has been passed over STARVE_LIMIT consecutive times.

package bus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    input  dbus_req_t  ireq,
    output dbus_resp_t iresp,
    output dbus_req_t  creq,
    input  dbus_resp_t cresp
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    typedef enum logic {
        OWN_D,
        OWN_I
    } owner_t;

    state_t        state;
    owner_t        owner;
    logic [CW-1:0] starve_cnt;

    logic          starved;
    logic          grant_i;
    logic          grant_d;
    logic          grant_any;
    logic          route_en;
    owner_t        sel;
    dbus_req_t     ireq_masked;

    // Grant selection, request forwarding and response routing.
    // Grant is decided combinationally in IDLE so the request reaches the
    // shared bus with no added latency; afterwards the registered owner holds.
    always_comb begin
        ireq_masked        = ireq;
        ireq_masked.strobe = '0;

        starved   = (starve_cnt == CW'(STARVE_LIMIT));
        grant_i   = ireq.valid && (!dreq.valid || starved);
        grant_d   = dreq.valid && !grant_i;
        grant_any = grant_i || grant_d;

        if (state == IDLE) begin
            sel      = grant_i ? OWN_I : OWN_D;
            route_en = grant_any;
        end else begin
            sel      = owner;
            route_en = 1'b1;
        end

        creq = (sel == OWN_I) ? ireq_masked : dreq;
        case (state)
            IDLE:    creq.valid = grant_any;
            ADDR:    creq.valid = (owner == OWN_I) ? ireq.valid : dreq.valid;
            default: creq.valid = 1'b0;
        endcase
        if (reset) begin
            creq.valid = 1'b0;
        end

        dresp.data    = cresp.data;
        iresp.data    = cresp.data;
        dresp.addr_ok = !reset && route_en && (sel == OWN_D) && cresp.addr_ok;
        dresp.data_ok = !reset && route_en && (sel == OWN_D) && cresp.data_ok;
        iresp.addr_ok = !reset && route_en && (sel == OWN_I) && cresp.addr_ok;
        iresp.data_ok = !reset && route_en && (sel == OWN_I) && cresp.data_ok;
    end

    // Transaction FSM, owner lock and instruction-port starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_D;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ireq.valid || grant_i) begin
                        starve_cnt <= '0;
                    end else if (grant_d && !starved) begin
                        starve_cnt <= starve_cnt + CW'(1);
                    end
                    if (grant_any) begin
                        owner <= sel;
                        if (cresp.data_ok) begin
                            state <= IDLE;
                        end else if (cresp.addr_ok) begin
                            state <= DATA;
                        end else begin
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (cresp.data_ok) begin
                        state <= IDLE;
                    end else if (cresp.addr_ok) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (cresp.data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
